// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and instruction field slices for the single-cycle MIPS core
package mips_pkg;

    // Sequencer state encoding; also visible on the state port
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;

    // Instruction field boundaries
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int JADDR_MSB  = 25;
    localparam int IMM_MSB    = 15;

    // Byte offset of a branch: sign-extended word displacement shifted left by two
    function automatic logic [31:0] branch_offset(input logic [31:0] instr);
        return {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection from jump, branch and zero flag
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zflag,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        unused_opcode;

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], instr[JADDR_MSB:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset(instr);

    // The opcode field is decoded by the control unit, not here
    assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zflag) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and run/step/halt sequencer for the MIPS core
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE  = HALT_OPCODE_DEFAULT,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic [31:0]          instr,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 zflag,
    output logic [31:0]          pc,
    output logic                 commit_en,
    output logic [1:0]           state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

    logic [31:0] next_pc;
    logic [1:0]  state_next;
    logic        is_halt;
    logic        exec;

    next_pc_calc u_next_pc_calc (
        .pc      (pc),
        .instr   (instr),
        .branch  (branch),
        .jump    (jump),
        .zflag   (zflag),
        .next_pc (next_pc)
    );

    assign is_halt   = (instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
    assign exec      = (state == ST_RUN) || (state == ST_STEP);
    assign commit_en = exec && !is_halt;
    assign halted    = (state == ST_HALT);

    // halt_req outranks step_req, which outranks run_req; RUN ignores step_req
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (halt_req) begin
                    state_next = state;
                end else if (step_req) begin
                    state_next = ST_STEP;
                end else if (run_req) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (is_halt || halt_req) begin
                    state_next = ST_HALT;
                end
            end
            ST_STEP: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (commit_en) begin
            pc <= {next_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (exec) begin
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            end
            if (commit_en) begin
                instret_count <= instret_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table with post-edge scoreboard for pc_sequencer
module tb_pc_sequencer;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    localparam logic [31:0] NOP = 32'h0000_0020;
    localparam logic [31:0] HLT = 32'hFC00_0000;
    localparam logic [31:0] JMP = 32'h0800_0040;
    localparam logic [31:0] BEQ = 32'h1000_0000;

    typedef struct {
        logic        rst, run, step, hlt;
        logic [31:0] instr;
        logic        br, jmp, z;
        logic        exp_commit;
        logic [31:0] exp_pc;
        logic [1:0]  exp_state;
        logic [31:0] exp_inst;
        logic [31:0] exp_cyc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [1:0]  state;
        logic [31:0] inst;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, run_req, step_req, halt_req;
    logic [31:0] instr;
    logic        branch, jump, zflag;
    logic [31:0] pc;
    logic        commit_en;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] cycle_count, instret_count;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .CLK           (clk),
        .reset         (reset),
        .run_req       (run_req),
        .step_req      (step_req),
        .halt_req      (halt_req),
        .instr         (instr),
        .branch        (branch),
        .jump          (jump),
        .zflag         (zflag),
        .pc            (pc),
        .commit_en     (commit_en),
        .state         (state),
        .halted        (halted),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s v%0d got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic add(input logic rst, input logic run, input logic step, input logic hlt,
                       input logic [31:0] ins, input logic br, input logic jmp, input logic z,
                       input logic ec, input logic [31:0] epc, input logic [1:0] est,
                       input logic [31:0] einst, input logic [31:0] ecyc);
        vec_t v;
        v.rst = rst; v.run = run; v.step = step; v.hlt = hlt;
        v.instr = ins; v.br = br; v.jmp = jmp; v.z = z;
        v.exp_commit = ec; v.exp_pc = epc; v.exp_state = est;
        v.exp_inst = einst; v.exp_cyc = ecyc;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        vec_t v;

        // Idle after reset
        for (int i = 0; i < 5; i++)
            add(0,0,0,0, NOP,0,0,0, 0, 32'h0, S_IDLE, 0, 0);
        // Sequential run and branches
        add(0,1,0,0, NOP,0,0,0,               0, 32'h0,   S_RUN, 0, 0);
        add(0,1,0,0, NOP,0,0,0,               1, 32'h4,   S_RUN, 1, 1);
        add(0,1,0,0, NOP,0,0,0,               1, 32'h8,   S_RUN, 2, 2);
        add(0,1,0,0, BEQ|32'hFFFE,1,0,1,      1, 32'h4,   S_RUN, 3, 3);
        add(0,1,0,0, NOP,0,0,0,               1, 32'h8,   S_RUN, 4, 4);
        add(0,1,0,0, BEQ|32'hFFFE,1,0,0,      1, 32'hC,   S_RUN, 5, 5);
        add(0,1,0,0, JMP,1,1,1,               1, 32'h100, S_RUN, 6, 6);
        add(0,1,0,0, BEQ|32'hFFC3,1,0,1,      1, 32'h10,  S_RUN, 7, 7);
        // Halt opcode at pc=16
        add(0,1,0,0, HLT,0,0,0,               0, 32'h10,  S_HALT, 7, 8);
        add(0,0,0,0, HLT,0,0,0,               0, 32'h10,  S_HALT, 7, 8);
        // Single step from HALT
        add(0,0,1,0, NOP,0,0,0,               0, 32'h10,  S_STEP, 7, 8);
        add(0,0,0,0, NOP,0,0,0,               1, 32'h14,  S_HALT, 8, 9);
        add(0,0,0,0, NOP,0,0,0,               0, 32'h14,  S_HALT, 8, 9);
        // halt_req beats step_req in HALT
        add(0,0,1,1, NOP,0,0,0,               0, 32'h14,  S_HALT, 8, 9);
        // halt_req in RUN commits current instruction
        add(0,1,0,0, NOP,0,0,0,               0, 32'h14,  S_RUN, 8, 9);
        add(0,1,0,1, NOP,0,0,0,               1, 32'h18,  S_HALT, 9, 10);
        // Held step_req: one instruction every two cycles
        add(0,0,1,0, NOP,0,0,0,               0, 32'h18,  S_STEP, 9, 10);
        add(0,0,1,0, NOP,0,0,0,               1, 32'h1C,  S_HALT, 10, 11);
        add(0,0,1,0, NOP,0,0,0,               0, 32'h1C,  S_STEP, 10, 11);
        add(0,0,1,0, NOP,0,0,0,               1, 32'h20,  S_HALT, 11, 12);
        // Step onto a halt word: one exec cycle, no commit
        add(0,0,1,0, NOP,0,0,0,               0, 32'h20,  S_STEP, 11, 12);
        add(0,0,0,0, HLT,0,0,0,               0, 32'h20,  S_HALT, 11, 13);
        // step_req ignored in RUN
        add(0,1,0,0, NOP,0,0,0,               0, 32'h20,  S_RUN, 11, 13);
        add(0,1,1,0, NOP,0,0,0,               1, 32'h24,  S_RUN, 12, 14);
        // Wrap at top of address space
        add(0,1,0,0, BEQ|32'hFFF5,1,0,1,      1, 32'hFFFF_FFFC, S_RUN, 13, 15);
        add(0,1,0,0, NOP,0,0,0,               1, 32'h0,   S_RUN, 14, 16);
        // Reset mid-run overrides requests
        add(1,1,0,0, NOP,0,0,0,               1, 32'h0,   S_IDLE, 0, 0);
        add(0,1,0,0, NOP,0,0,0,               0, 32'h0,   S_RUN, 0, 0);
        // Halt word beats jump: pc holds
        add(0,1,0,0, HLT,0,1,0,               0, 32'h0,   S_HALT, 0, 1);

        reset = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        instr = NOP; branch = 1'b0; jump = 1'b0; zflag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",      -1, pc, 32'h0);
        chk("rst_state",   -1, {30'd0, state}, {30'd0, S_IDLE});
        chk("rst_commit",  -1, {31'd0, commit_en}, 32'd0);
        chk("rst_halted",  -1, {31'd0, halted}, 32'd0);
        chk("rst_cycle",   -1, cycle_count, 32'd0);
        chk("rst_instret", -1, instret_count, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            reset = v.rst; run_req = v.run; step_req = v.step; halt_req = v.hlt;
            instr = v.instr; branch = v.br; jump = v.jmp; zflag = v.z;
            #1;
            chk("commit_en", i, {31'd0, commit_en}, {31'd0, v.exp_commit});
            e.idx = i; e.pc = v.exp_pc; e.state = v.exp_state;
            e.inst = v.exp_inst; e.cyc = v.exp_cyc;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard v%0d got empty want entry", i);
            end else begin
                e = sb.pop_front();
                chk("pc",      e.idx, pc, e.pc);
                chk("pc_low",  e.idx, {30'd0, pc[1:0]}, 32'd0);
                chk("state",   e.idx, {30'd0, state}, {30'd0, e.state});
                chk("halted",  e.idx, {31'd0, halted}, {31'd0, (e.state == S_HALT)});
                chk("instret", e.idx, instret_count, e.inst);
                chk("cycle",   e.idx, cycle_count, e.cyc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
